// File: rtl/ara_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ara_pkg
//  Description : Shared types for the ring endpoint. It holds the vector
//                element word type, the remote-data payload carried on the
//                ring, and the endpoint transfer-state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package ara_pkg;

  localparam int unsigned ELEN = 64;

  typedef logic [ELEN-1:0] elen_t;

  // Payload of one ring word exchanged between neighbouring clusters.
  typedef struct packed {
    elen_t data;
  } remote_data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } ring_ep_state_e;

endpackage : ara_pkg
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_v3
//  Description : Synchronous FIFO with the common_cells fifo_v3 interface.
//                With FALL_THROUGH=0 a pushed word becomes visible on data_o
//                one cycle after the push. full_o/empty_o come from the
//                registered occupancy only.
//  Ports       : clk_i, rst_ni (async, active low), flush_i, testmode_i
//                full_o, empty_o, usage_o   - occupancy status
//                data_i/push_i              - write side
//                data_o/pop_i               - read side
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH:0]   c_DEPTH = (ADDR_DEPTH + 1)'(DEPTH);
  localparam logic [ADDR_DEPTH-1:0] c_LAST  = ADDR_DEPTH'(DEPTH - 1);

  logic [ADDR_DEPTH-1:0] r_rd_ptr;
  logic [ADDR_DEPTH-1:0] r_wr_ptr;
  logic [ADDR_DEPTH:0]   r_cnt;
  dtype                  r_mem [DEPTH];

  logic w_bypass;
  logic w_write;
  logic w_read;
  logic w_unused_testmode;

  assign w_unused_testmode = testmode_i;

  // In fall-through mode a push into an empty FIFO that is popped in the
  // same cycle never touches the storage.
  assign w_bypass = FALL_THROUGH && (r_cnt == '0) && push_i && pop_i;
  assign w_write  = push_i && (r_cnt != c_DEPTH) && !w_bypass;
  assign w_read   = pop_i && (r_cnt != '0);

  assign full_o  = (r_cnt == c_DEPTH);
  assign empty_o = (r_cnt == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = r_cnt[ADDR_DEPTH-1:0];
  assign data_o  = (FALL_THROUGH && (r_cnt == '0)) ? data_i : r_mem[r_rd_ptr];

  function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] p);
    return (p == c_LAST) ? '0 : p + ADDR_DEPTH'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_write) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_read)  r_rd_ptr <= next_ptr(r_rd_ptr);
      r_cnt <= r_cnt + {{ADDR_DEPTH{1'b0}}, w_write} - {{ADDR_DEPTH{1'b0}}, w_read};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_write) r_mem[r_wr_ptr] <= data_i;
  end

endmodule : fifo_v3
`default_nettype wire

// File: rtl/ring_endpoint.sv
`default_nettype none
// ============================================================================
//  Module      : ring_endpoint
//  Description : Cluster endpoint on the inter-cluster slide ring. A transfer
//                request moves req_len_i words from the slide unit onto the
//                ring through a one-word output register, and waits until the
//                same number of words has been received from the ring. Ring
//                words are buffered in an Rx FIFO in every state, so words
//                arriving before the local request (cluster skew) are kept.
//  Ports       : clk_i, rst_ni (async, active low)
//                req_valid_i/req_ready_o, req_len_i, req_dir_i - request
//                tx_data_i/tx_valid_i/tx_ready_o             - slide -> ep
//                ring_data_o/ring_valid_o/ring_ready_i       - ep -> router
//                ring_data_i/ring_valid_i/ring_ready_o       - router -> ep
//                rx_data_o/rx_valid_o/rx_ready_i             - ep -> slide
//                dir_o (registered direction), done_o (completion pulse)
//                stall_cnt_o (only with RING_ENDPOINT_STATS_EN defined)
//  Revision    : 1.0 - initial release
// ============================================================================
module ring_endpoint
  import ara_pkg::*;
#(
  parameter int unsigned NrClusters  = 1,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned RxFifoDepth = 4,
  parameter int unsigned LenWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [LenWidth-1:0]  req_len_i,
  input  logic                 req_dir_i,
  input  logic [DataWidth-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic [DataWidth-1:0] ring_data_o,
  output logic                 ring_valid_o,
  input  logic                 ring_ready_i,
  input  logic [DataWidth-1:0] ring_data_i,
  input  logic                 ring_valid_i,
  output logic                 ring_ready_o,
  output logic [DataWidth-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 dir_o,
  output logic                 done_o
`ifdef RING_ENDPOINT_STATS_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int unsigned c_FIFO_AW = $clog2(RxFifoDepth);

  if ((NrClusters < 1) || (RxFifoDepth < 2) ||
      ((RxFifoDepth & (RxFifoDepth - 1)) != 0) ||
      (DataWidth != $bits(elen_t))) begin : g_param_check
    $error("ring_endpoint: illegal parameter combination");
  end

  ring_ep_state_e        r_state;
  ring_ep_state_e        w_state_next;
  logic                  w_accept;

  logic [LenWidth-1:0]   r_len;
  logic [LenWidth-1:0]   r_tx_cnt;
  logic [LenWidth:0]     r_rx_cnt;
  logic [LenWidth:0]     w_rx_dec;
  logic                  r_dir;

  logic                  r_ring_valid;
  logic [DataWidth-1:0]  r_ring_data;

  logic                  w_tx_fire;
  logic                  w_tx_all;
  logic                  w_rx_enough;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_ring_push;
  logic [c_FIFO_AW-1:0]  w_unused_usage;

  // --------------------------------------------------------------------------
  // Transfer FSM
  // --------------------------------------------------------------------------
  assign w_tx_all    = (r_tx_cnt == r_len);
  assign w_rx_enough = (r_rx_cnt >= {1'b0, r_len});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    req_ready_o  = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = XFER;
        end
      end
      XFER: begin
        // The output register must have drained so the last word is really
        // on the ring before completion is signalled.
        if (w_tx_all && !r_ring_valid && w_rx_enough) w_state_next = DONE;
      end
      DONE: begin
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len    <= '0;
      r_dir    <= 1'b0;
      r_tx_cnt <= '0;
    end else if (w_accept) begin
      r_len    <= req_len_i;
      r_dir    <= req_dir_i;
      r_tx_cnt <= '0;
    end else if (w_tx_fire) begin
      r_tx_cnt <= r_tx_cnt + LenWidth'(1);
    end
  end

  assign dir_o = r_dir;

  // --------------------------------------------------------------------------
  // Tx path: single pipeline register towards the router
  // --------------------------------------------------------------------------
  assign tx_ready_o = (r_state == XFER) && (r_tx_cnt < r_len) &&
                      (!r_ring_valid || ring_ready_i);
  assign w_tx_fire  = tx_valid_i && tx_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ring_valid <= 1'b0;
      r_ring_data  <= '0;
    end else if (w_tx_fire) begin
      r_ring_valid <= 1'b1;
      r_ring_data  <= tx_data_i;
    end else if (ring_ready_i) begin
      r_ring_valid <= 1'b0;
    end
  end

  assign ring_valid_o = r_ring_valid;
  assign ring_data_o  = r_ring_data;

  // --------------------------------------------------------------------------
  // Rx path: FIFO accepts in every state; ready depends on occupancy only
  // --------------------------------------------------------------------------
  assign ring_ready_o = !w_fifo_full;
  assign w_ring_push  = ring_valid_i && !w_fifo_full;
  assign rx_valid_o   = !w_fifo_empty;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DataWidth),
    .DEPTH        (RxFifoDepth),
    .dtype        (logic [DataWidth-1:0])
  ) i_rx_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (w_fifo_full),
    .empty_o    (w_fifo_empty),
    .usage_o    (w_unused_usage),
    .data_i     (ring_data_i),
    .push_i     (w_ring_push),
    .data_o     (rx_data_o),
    .pop_i      (rx_ready_i)
  );

  // Received-word credit. Words from a neighbour that started earlier are
  // counted before the local request; each completed transfer consumes its
  // length, so surplus credit carries into the next transfer.
  assign w_rx_dec = (r_state == DONE) ? {1'b0, r_len} : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rx_cnt <= '0;
    else         r_rx_cnt <= r_rx_cnt + {{LenWidth{1'b0}}, w_ring_push} - w_rx_dec;
  end

`ifdef RING_ENDPOINT_STATS_EN
  // --------------------------------------------------------------------------
  // Backpressure statistics
  // --------------------------------------------------------------------------
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  assign w_stall = (r_state == XFER) &&
                   ((r_ring_valid && !ring_ready_i) || (ring_valid_i && w_fifo_full));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                               r_stall_cnt <= '0;
    else if (w_accept)                         r_stall_cnt <= '0;
    else if (w_stall && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule : ring_endpoint
`default_nettype wire
